// File: rtl/nor_32bit.sv
// Registered 32-bit bitwise NOR unit for the MiniMIPS ALU datapath.
// A combinational array of 1-bit NOR slices feeds a separate output register stage.

module nor_slice (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = ~(a | b);

endmodule

module nor_32bit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] value1,
  input  logic [31:0] value2,
  input  logic        in_valid,
  output logic [31:0] result,
  output logic        out_valid,
  output logic        zero
);

  logic [31:0] nor_bits;
  logic        nor_zero;

  // Each slice is independent; there is no carry or sign handling between bits.
  for (genvar i = 0; i < 32; i++) begin : g_slice
    nor_slice u_slice (
      .a (value1[i]),
      .b (value2[i]),
      .y (nor_bits[i])
    );
  end

  assign nor_zero = (nor_bits == 32'h0000_0000);

  // Reset is synchronous; zero clears to 0 even though result clears to 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      result    <= 32'h0000_0000;
      zero      <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      result    <= nor_bits;
      zero      <= nor_zero;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nor_32bit.sv
// Self-checking bench for nor_32bit: directed vectors, hold, reset cases and
// random traffic compared against a cycle-level reference model.

module tb_nor_32bit;

  logic        clk;
  logic        rst_n;
  logic [31:0] value1;
  logic [31:0] value2;
  logic        in_valid;
  logic [31:0] result;
  logic        out_valid;
  logic        zero;

  int checks;
  int errors;
  int accepts;
  int valids;

  // Reference model state: what the outputs must show after the latest edge.
  logic [31:0] m_result;
  logic        m_zero;
  logic        m_valid;

  nor_32bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .value1    (value1),
    .value2    (value2),
    .in_valid  (in_valid),
    .result    (result),
    .out_valid (out_valid),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: got %08h, expected %08h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, advance the model at the
  // rising edge and compare all outputs shortly afterwards.
  task automatic step(input logic rst, input logic iv,
                      input logic [31:0] a, input logic [31:0] b);
    logic [31:0] nor_ab;
    @(negedge clk);
    rst_n    = rst;
    in_valid = iv;
    value1   = a;
    value2   = b;
    #1;
    check("no_comb_path", result, m_result);
    @(posedge clk);
    nor_ab = (~a) & (~b);
    if (!rst) begin
      m_result = 32'h0;
      m_zero   = 1'b0;
      m_valid  = 1'b0;
    end else if (iv) begin
      m_result = nor_ab;
      m_zero   = (nor_ab == 32'h0);
      m_valid  = 1'b1;
      accepts++;
    end else begin
      m_valid  = 1'b0;
    end
    #1;
    if (out_valid === 1'b1) valids++;
    check("result", result, m_result);
    check("zero", {31'b0, zero}, {31'b0, m_zero});
    check("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    accepts  = 0;
    valids   = 0;
    m_result = 32'h0;
    m_zero   = 1'b0;
    m_valid  = 1'b0;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    value1   = 32'h1234_5678;
    value2   = 32'h0;

    // Reset with a live operation presented: it must be discarded.
    step(1'b0, 1'b1, 32'h1111_0000, 32'h0000_2222);
    step(1'b0, 1'b1, 32'h0, 32'h0);
    check("rst_result", result, 32'h0);
    check("rst_zero", {31'b0, zero}, 32'h0);

    // Directed vectors, back to back.
    step(1'b1, 1'b1, 32'hF000_F000, 32'h0F00_1000);
    check("dir0", result, 32'h00FF_0FFF);
    step(1'b1, 1'b1, 32'hFFFF_0000, 32'h0000_FFFF);
    check("dir1_zero", {31'b0, zero}, 32'h1);
    step(1'b1, 1'b1, 32'h0F0F_0F0F, 32'h0A0A_0A0A);
    check("dir2", result, 32'hF0F0_F0F0);
    step(1'b1, 1'b1, 32'hAAAA_AAAA, 32'hFFFF_FFFF);
    check("dir3", result, 32'h0);

    // Identity edge cases.
    step(1'b1, 1'b1, 32'h0, 32'h0);
    check("all_zero_in", result, 32'hFFFF_FFFF);
    step(1'b1, 1'b1, 32'h1234_5678, 32'h1234_5678);
    check("x_nor_x", result, 32'hEDCB_A987);
    step(1'b1, 1'b1, 32'h1234_5678, ~32'h1234_5678);
    check("x_nor_notx_zero", {31'b0, zero}, 32'h1);

    // Hold: outputs freeze while in_valid is low and operands wander.
    step(1'b1, 1'b1, 32'hF000_F000, 32'h0F00_1000);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, $urandom, $urandom);
      check("hold", result, 32'h00FF_0FFF);
    end

    // Reset mid-stream, then resume with one-cycle latency.
    step(1'b1, 1'b1, 32'h0000_00FF, 32'h0000_0F00);
    step(1'b0, 1'b1, 32'h1, 32'h2);
    check("mid_rst_valid", {31'b0, out_valid}, 32'h0);
    step(1'b1, 1'b1, 32'h8000_0000, 32'h0000_0001);
    check("post_rst", result, 32'h7FFF_FFFE);

    // Random traffic with occasional sparse operands to hit zero often.
    for (int i = 0; i < 10000; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? ~a : $urandom;
      step(($urandom_range(0, 99) != 0), $urandom_range(0, 1) == 1, a, b);
    end

    check("valid_count", valids, accepts);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nor_32bit.md
# nor_32bit

Registered 32-bit bitwise NOR unit for the MiniMIPS ALU datapath. Each result bit is the NOR of the corresponding bits of two 32-bit operands, with no inter-bit dependency. The result is captured into an output register on each accepted operation and published with a valid strobe and a zero flag. The ALU uses it for the MIPS `nor` instruction.

## Interface
- Parameters: none; the width is fixed at 32 bits.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- value1  input  32  operand A.
- value2  input  32  operand B.
- in_valid  input  1  operands valid this cycle; an operation is accepted when high at the rising edge.
- result  output  32  registered NOR result.
- out_valid  output  1  high for exactly one cycle per accepted operation, aligned with the new result.
- zero  output  1  registered flag; 1 when the captured result equals 32'h00000000.

## Operation
- Per bit i in 0..31: result[i] = ~(value1[i] | value2[i]).
  - Purely bitwise, with no carry, overflow or sign handling.
  - The inputs are treated as raw bit vectors; signedness is irrelevant.
- On accept (rst_n=1, in_valid=1):
  - result <= ~(value1 | value2).
  - zero <= (~(value1 | value2) == 0).
  - out_valid <= 1.
- When rst_n=1 and in_valid=0:
  - result and zero hold their previous values.
  - out_valid <= 0.
- The combinational NOR network feeding the registers is built as 32 independent 1-bit NOR slices.
- The register stage is separate from the combinational network.
- No X-propagation masking.
- No backpressure: every accepted operation is always consumed. The unit has no ready output.

## Timing
- Latency is 1 cycle. Operands sampled at edge N appear on result/zero/out_valid after edge N and stay stable until the next accept.
- Throughput is one operation per cycle. Back-to-back accepts each produce a fresh result on consecutive cycles, and out_valid stays high continuously.
- Reset is sampled only at the rising edge. When rst_n=0 at the edge:
  - result = 32'h00000000.
  - zero = 0.
  - out_valid = 0.
- Reset takes priority over in_valid; an operation presented during reset is discarded.
- Deassertion of rst_n takes effect at the next edge.
- Reset asserted mid-stream drops any pending output. out_valid is 0 on the cycle after the reset edge.
- Operand changes between edges have no effect on the outputs; there is no combinational path from inputs to outputs.

## Test plan
- **Reset:** hold rst_n=0 for 2 cycles with in_valid=1 and arbitrary operands -> result=00000000, zero=0, out_valid=0 throughout.
- **Directed vectors,** one accept per cycle:
  - F000F000 / 0F001000 -> 00FF0FFF, zero=0.
  - FFFF0000 / 0000FFFF -> 00000000, zero=1.
  - 0F0F0F0F / 0A0A0A0A -> F0F0F0F0, zero=0.
  - AAAAAAAA / FFFFFFFF -> 00000000, zero=1.
  - Each vector gets out_valid=1 one cycle after its accept.
- **Identity edge cases:**
  - 00000000 / 00000000 -> FFFFFFFF, zero=0.
  - X / X with X=12345678 -> EDCBA987.
  - X / ~X -> 00000000, zero=1.
- **Hold:** accept F000F000/0F001000, then drop in_valid and change operands for 3 cycles -> result stays 00FF0FFF, out_valid=0 after the first cycle.
- **Reset mid-stream:** back-to-back accepts with rst_n pulled low for one edge -> outputs cleared at that edge, then normal operation resumes with 1-cycle latency.
- **Random:** 10k random operand pairs with random in_valid -> every result matches ~(a|b), zero matches result==0, and the out_valid count equals the accept count.
